// File: rtl/mpu_matrix_streamer.sv
// Streams a captured 5x5 signed 8-bit matrix one element per handshake in row-major order,
// optionally negating each element with saturation of -128 to +127.
module mpu_matrix_streamer (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [199:0] matrix_in,
    input  logic         negate,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic [2:0]   out_row,
    output logic [2:0]   out_col,
    output logic         out_last,
    output logic         sat_flag
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e         state_q, state_d;
    logic [199:0]   mat_q, mat_d;
    logic           neg_q, neg_d;
    logic [2:0]     row_q, row_d;
    logic [2:0]     col_q, col_d;
    logic           sat_q, sat_d;

    logic           load_hs;
    logic           out_hs;
    logic           is_last;
    logic [7:0]     head;
    logic           head_min;
    logic [7:0]     head_val;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (load_valid) state_d = StStream;
            StStream: if (out_ready && is_last) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mat_q <= '0;
            neg_q <= 1'b0;
            row_q <= 3'd0;
            col_q <= 3'd0;
            sat_q <= 1'b0;
        end else begin
            mat_q <= mat_d;
            neg_q <= neg_d;
            row_q <= row_d;
            col_q <= col_d;
            sat_q <= sat_d;
        end
    end

    // The captured matrix shifts down one element per handshake, so the current one is always
    // in the low byte.
    assign head     = mat_q[7:0];
    assign head_min = (head == 8'h80);
    assign is_last  = (row_q == 3'd4) && (col_q == 3'd4);
    assign load_hs  = load_valid && load_ready;
    assign out_hs   = out_valid && out_ready;

    always_comb begin
        mat_d = mat_q;
        neg_d = neg_q;
        row_d = row_q;
        col_d = col_q;
        sat_d = sat_q;
        if (load_hs) begin
            mat_d = matrix_in;
            neg_d = negate;
            row_d = 3'd0;
            col_d = 3'd0;
            sat_d = 1'b0;
        end else if (out_hs) begin
            mat_d = {8'h00, mat_q[199:8]};
            sat_d = sat_q | (neg_q & head_min);
            if (col_q == 3'd4) begin
                col_d = 3'd0;
                row_d = (row_q == 3'd4) ? 3'd0 : row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    always_comb begin
        if (!neg_q) begin
            head_val = head;
        end else if (head_min) begin
            head_val = 8'h7f;
        end else begin
            head_val = ~head + 8'd1;
        end
    end

    // Output logic
    always_comb begin
        load_ready = (state_q == StIdle);
        out_valid  = (state_q == StStream);
        out_data   = 8'h00;
        out_row    = 3'd0;
        out_col    = 3'd0;
        out_last   = 1'b0;
        if (state_q == StStream) begin
            out_data = head_val;
            out_row  = row_q;
            out_col  = col_q;
            out_last = is_last;
        end
        sat_flag = sat_q;
    end

endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// Self-checking bench for mpu_matrix_streamer: table of fixed matrices, randomized streams
// against an arithmetic reference model, and hand-written reset / back-to-back sequences.
module tb_mpu_matrix_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic         load_ready;
    logic [199:0] matrix_in;
    logic         negate;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [2:0]   out_row;
    logic [2:0]   out_col;
    logic         out_last;
    logic         sat_flag;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mpu_matrix_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .matrix_in  (matrix_in),
        .negate     (negate),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .sat_flag   (sat_flag)
    );

    typedef struct {
        logic [199:0] mat;
        bit           neg;
        bit           rnd_ready;
        bit           scramble;
        bit           hold_load;
        bit           exp_sat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: plain integer negation clamped to the 8-bit signed range.
    function automatic logic [7:0] exp_elem(input logic [199:0] m, input int k, input bit neg);
        int v;
        v = int'($signed(m[8*k +: 8]));
        if (neg) v = -v;
        if (v > 127) v = 127;
        return 8'(v);
    endfunction

    function automatic logic [199:0] rand_mat();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[32*i +: 32] = $urandom;
        return t[199:0];
    endfunction

    function automatic logic [199:0] ramp();
        logic [199:0] m;
        for (int k = 0; k < 25; k++) m[8*k +: 8] = 8'(k);
        return m;
    endfunction

    // Entered at a negedge with the DUT idle; leaves at the negedge after acceptance.
    task automatic do_load(input logic [199:0] m, input bit neg);
        chk("load_ready_idle", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        matrix_in  = m;
        negate     = neg;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic stream(input logic [199:0] m, input bit neg, input bit rnd_ready,
                          input bit scramble, input bit hold_load, output bit sat_end);
        int k   = 0;
        int cyc = 0;
        bit sat = 1'b0;
        while (k < 25 && cyc < 400) begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("load_ready_busy", 32'(load_ready), 32'd0);
            chk("out_data", 32'(out_data), 32'(exp_elem(m, k, neg)));
            chk("out_row", 32'(out_row), 32'(k / 5));
            chk("out_col", 32'(out_col), 32'(k % 5));
            chk("out_last", 32'(out_last), 32'(k == 24));
            chk("sat_flag", 32'(sat_flag), 32'(sat));
            if (scramble) begin
                matrix_in = rand_mat();
                negate    = 1'($urandom);
            end
            load_valid = hold_load;
            out_ready  = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk);
            if (out_ready) begin
                if (neg && m[8*k +: 8] == 8'h80) sat = 1'b1;
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        if (k < 25) chk("stream_timeout", 32'(k), 32'd25);
        if (!rnd_ready) chk("throughput_cycles", 32'(cyc), 32'd25);
        out_ready = 1'b0;
        chk("end_out_valid", 32'(out_valid), 32'd0);
        chk("end_load_ready", 32'(load_ready), 32'd1);
        chk("end_out_data", 32'(out_data), 32'd0);
        chk("end_rowcol", {26'd0, out_row, out_col}, 32'd0);
        chk("end_out_last", 32'(out_last), 32'd0);
        chk("end_sat", 32'(sat_flag), 32'(sat));
        load_valid = 1'b0;
        sat_end = sat;
    endtask

    vec_t         vecs[6];
    logic [199:0] m;
    bit           s;

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        matrix_in  = '0;
        negate     = 1'b0;
        out_ready  = 1'b0;

        m = ramp();
        vecs[0] = '{m, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{m, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{m, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        m[8*3 +: 8] = 8'h80;
        m[8*4 +: 8] = 8'h7f;
        vecs[2] = '{m, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{m, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        m = {25{8'h80}};
        vecs[5] = '{m, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", {19'd0, out_data, out_row, out_col, out_last}, 32'd0);
        chk("rst_sat", 32'(sat_flag), 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_load(vecs[i].mat, vecs[i].neg);
            stream(vecs[i].mat, vecs[i].neg, vecs[i].rnd_ready, vecs[i].scramble,
                   vecs[i].hold_load, s);
            chk("vec_sat", 32'(sat_flag), 32'(vecs[i].exp_sat));
        end

        for (int i = 0; i < 8; i++) begin
            m = rand_mat();
            if (i < 4) m[8*$urandom_range(0, 24) +: 8] = 8'h80;
            s = 1'($urandom);
            do_load(m, s);
            stream(m, s, 1'b1, 1'b1, 1'($urandom), s);
        end

        // Abort a stream after ten elements; reset also beats a pending load and output handshake.
        m = ramp();
        m[8*2 +: 8] = 8'h80;
        do_load(m, 1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("pre_rst_data", 32'(out_data), 32'(exp_elem(m, k, 1'b1)));
            @(negedge clk);
        end
        chk("pre_rst_sat", 32'(sat_flag), 32'd1);
        reset      = 1'b1;
        load_valid = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        load_valid = 1'b0;
        out_ready  = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_load_ready", 32'(load_ready), 32'd1);
        chk("abort_outputs", {19'd0, out_data, out_row, out_col, out_last}, 32'd0);
        chk("abort_sat", 32'(sat_flag), 32'd0);
        m = ramp();
        do_load(m, 1'b0);
        stream(m, 1'b0, 1'b0, 1'b0, 1'b0, s);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
